// File: rtl/skullfet_pkg.sv
// Shared types and constants for the skullfet cell exerciser.
//   state_e       : sweep FSM states
//   NUM_VECTORS   : number of stimulus vectors per sweep (2-bit index)
//   ch_idx_w()    : width of a channel index, never less than 1
package skullfet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned VEC_W       = 2;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skullfet_sync2.sv
// Two-flop synchroniser for the asynchronous pad responses.
//   clk, rst : clock and asynchronous active-high reset
//   d        : asynchronous input bus
//   q        : synchronised output bus (two cycles of latency)
module skullfet_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/skullfet_exerciser.sv
// Sweeps all four 2-bit input vectors across skullfet inverter and NAND
// channels, compares the synchronised pad responses with the ideal logic
// function and reports mismatch statistics.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   start_i            : request one sweep (IDLE only)
//   continuous_i       : auto-restart after each sweep (sampled in DONE)
//   stim_o             : cell inputs, inverter A bits then NAND {B,A} pairs
//   resp_i             : cell outputs, inverters then NANDs (asynchronous)
//   busy_o, done_o     : sweep in progress / one-cycle end-of-sweep pulse
//   pass_o             : last completed sweep had no mismatches
//   err_count_o        : saturating mismatch count of current/last sweep
//   first_fail_o       : lowest channel of the first failing sample
//   fail_seen_o        : any mismatch since the sweep started
//   sweep_count_o      : completed sweeps, wrapping
module skullfet_exerciser
  import skullfet_pkg::*;
#(
  parameter int unsigned NUM_INV       = 1,
  parameter int unsigned NUM_NAND      = 1,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                                         wb_clk_i,
  input  logic                                         wb_rst_i,
  input  logic                                         start_i,
  input  logic                                         continuous_i,
  output logic [NUM_INV+2*NUM_NAND-1:0]                stim_o,
  input  logic [NUM_INV+NUM_NAND-1:0]                  resp_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         pass_o,
  output logic [CNT_W-1:0]                             err_count_o,
  output logic [ch_idx_w(NUM_INV+NUM_NAND)-1:0]        first_fail_o,
  output logic                                         fail_seen_o,
  output logic [CNT_W-1:0]                             sweep_count_o
);

  localparam int unsigned NUM_CH = NUM_INV + NUM_NAND;
  localparam int unsigned STIM_W = NUM_INV + 2 * NUM_NAND;
  localparam int unsigned FF_W   = ch_idx_w(NUM_CH);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned POP_W  = $clog2(NUM_CH + 1);
  localparam int unsigned SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_e              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [SET_W-1:0]    settle_q;
  logic                settle_done;
  logic                start_sweep;
  logic [STIM_W-1:0]   stim_vec, stim_d;
  logic [NUM_CH-1:0]   resp_sync, resp_exp, mismatch;
  logic [POP_W-1:0]    mm_cnt;
  logic [FF_W-1:0]     mm_low;
  logic                mm_found;
  logic [SUM_W-1:0]    err_sum;
  logic [CNT_W-1:0]    err_next;

  skullfet_sync2 #(.WIDTH(NUM_CH)) u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (resp_i),
    .q   (resp_sync)
  );

  // Next state, next vector and next stimulus
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    start_sweep = 1'b0;
    stim_d      = stim_o;
    settle_done = (settle_q == SET_W'(SETTLE_CYCLES - 1));
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_DRIVE;
          start_sweep = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (settle_done) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (vec_q == VEC_W'(NUM_VECTORS - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          vec_d   = VEC_W'(vec_q + 1'b1);
        end
      end
      ST_DONE: begin
        if (continuous_i) begin
          state_d     = ST_DRIVE;
          start_sweep = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_sweep) vec_d = '0;
    // Stimulus only moves on the edge into DRIVE; parked at 0 otherwise
    if (state_d == ST_DRIVE && state_q != ST_DRIVE) begin
      stim_d = stim_vec;
    end else if (state_d == ST_IDLE || state_d == ST_DONE) begin
      stim_d = '0;
    end
  end

  // Stimulus pattern for the vector about to be driven
  always_comb begin
    stim_vec = '0;
    for (int i = 0; i < NUM_INV; i++) stim_vec[i] = vec_d[0];
    for (int j = 0; j < NUM_NAND; j++) begin
      stim_vec[NUM_INV + 2*j]     = vec_d[0];
      stim_vec[NUM_INV + 2*j + 1] = vec_d[1];
    end
  end

  // Ideal responses for the vector currently held, and mismatch statistics
  always_comb begin
    resp_exp = '0;
    for (int i = 0; i < NUM_INV; i++) resp_exp[i] = ~vec_q[0];
    for (int j = 0; j < NUM_NAND; j++) resp_exp[NUM_INV + j] = ~(vec_q[0] & vec_q[1]);
    mismatch = resp_sync ^ resp_exp;
    mm_cnt   = '0;
    mm_low   = '0;
    mm_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      mm_cnt = POP_W'(mm_cnt + POP_W'(mismatch[i]));
      if (mismatch[i] && !mm_found) begin
        mm_low   = FF_W'(i);
        mm_found = 1'b1;
      end
    end
    err_sum  = SUM_W'(err_count_o) + SUM_W'(mm_cnt);
    err_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : CNT_W'(err_sum);
  end

  // State register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      vec_q         <= '0;
      settle_q      <= '0;
      stim_o        <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      err_count_o   <= '0;
      first_fail_o  <= '0;
      fail_seen_o   <= 1'b0;
      sweep_count_o <= '0;
    end else begin
      vec_q  <= vec_d;
      stim_o <= stim_d;
      busy_o <= (state_d != ST_IDLE);
      done_o <= (state_d == ST_DONE);
      if (state_q == ST_DRIVE && !settle_done) settle_q <= SET_W'(settle_q + 1'b1);
      else                                     settle_q <= '0;
      if (start_sweep) begin
        err_count_o  <= '0;
        first_fail_o <= '0;
        fail_seen_o  <= 1'b0;
      end else if (state_q == ST_SAMPLE) begin
        err_count_o <= err_next;
        if (mm_found && !fail_seen_o) begin
          first_fail_o <= mm_low;
          fail_seen_o  <= 1'b1;
        end
      end
      if (state_q == ST_SAMPLE && state_d == ST_DONE) begin
        pass_o        <= (err_next == '0);
        sweep_count_o <= CNT_W'(sweep_count_o + 1'b1);
      end
    end
  end

endmodule
